// File: rtl/fsm_chk_pkg.sv
// Shared definitions for the stepper state-code sequence checker.
//   - chk_state_t : tracker state (SYNC while hunting for IDLE, TRACK once locked)
//   - CODE_*      : state codes emitted by the three-state stepper
//   - DEFAULT_LAST_CODE : highest legal code of the stepper
//   - next_ok()   : legality of a prev -> code transition (hold, step or wrap)
package fsm_chk_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } chk_state_t;

  localparam int unsigned CODE_IDLE = 0;
  localparam int unsigned CODE_S1   = 1;
  localparam int unsigned CODE_S2   = 2;

  localparam int unsigned DEFAULT_LAST_CODE = CODE_S2;

  // A transition is legal when the code holds, advances by one below the last
  // code, or wraps from the last code back to IDLE. Anything above 'last' can
  // never satisfy any of the three, because prev itself is always <= last.
  function automatic logic next_ok(input int unsigned prev,
                                   input int unsigned code,
                                   input int unsigned last);
    logic hold;
    logic step;
    logic wrap;
    hold = (code == prev);
    step = (prev < last) && (code == prev + CODE_S1);
    wrap = (prev == last) && (code == CODE_IDLE);
    return hold || step || wrap;
  endfunction

endpackage

// File: rtl/fsm_chk_endly.sv
// Two-stage delay of the stepper enable, matching the stepper's state-register
// plus output-register latency so that en_d2 lines up with the code transition
// it caused. Only instantiated when CHK_EN_CORR_EN is defined.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : stepper enable as seen by the stepper
//   flush      : synchronous clear of both stages (checker dropping to SYNC)
//   en_d2      : enable delayed by two clocks
module fsm_chk_endly
  import fsm_chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic flush,
  output logic en_d2
);

  logic en_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1 <= 1'b0;
      en_d2 <= 1'b0;
    end else if (flush) begin
      en_d1 <= 1'b0;
      en_d2 <= 1'b0;
    end else begin
      en_d1 <= en;
      en_d2 <= en_d1;
    end
  end

endmodule

// File: rtl/fsm_seq_checker.sv
// Receive-side monitor for the stepper's state-code stream. Locks on the first
// IDLE code, then checks every transition, counts completed rounds and illegal
// transitions, and captures the first offending {prev, code} pair.
// Optional feature macro: CHK_EN_CORR_EN -- adds the 'en' input and requires
// the observed transitions to agree with the enable delayed by two clocks.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   en         : stepper enable (only with CHK_EN_CORR_EN)
//   code       : observed state code, sampled every rising edge
//   clr        : synchronous clear of counters, sticky flag and capture
//   locked     : 1 while tracking a legal sequence
//   err_pulse  : one-cycle pulse per illegal transition
//   err_sticky : set on any error until clr or reset
//   err_cnt    : saturating error count
//   rnd_cnt    : count of LAST_CODE -> 0 wraps, modulo 2^RND_W
//   err_info   : {prev_code, bad_code} of the first error since clear
module fsm_seq_checker
  import fsm_chk_pkg::*;
#(
  parameter int CODE_W    = 4,
  parameter int LAST_CODE = DEFAULT_LAST_CODE,
  parameter int RND_W     = 8,
  parameter int ERR_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CHK_EN_CORR_EN
  input  logic                en,
`endif
  input  logic [CODE_W-1:0]   code,
  input  logic                clr,
  output logic                locked,
  output logic                err_pulse,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [RND_W-1:0]    rnd_cnt,
  output logic [2*CODE_W-1:0] err_info
);

  localparam int unsigned       LAST_U = LAST_CODE;
  localparam logic [CODE_W-1:0] IDLE_C = CODE_W'(CODE_IDLE);

  chk_state_t          state_q, state_d;
  logic [CODE_W-1:0]   prev_q, prev_d;

  logic                is_hold;
  logic                is_wrap;
  logic                base_ok;
  logic                en_ok;
  logic                legal;
  logic                err_ev;
  logic                wrap_ev;

  logic [ERR_W-1:0]    err_base, err_cnt_d;
  logic [RND_W-1:0]    rnd_base, rnd_cnt_d;
  logic [2*CODE_W-1:0] info_base, err_info_d;
  logic                sticky_base, err_sticky_d;

`ifdef CHK_EN_CORR_EN
  logic en_d2;

  // The delay line is flushed on the same edge that drops the tracker to SYNC,
  // so enables from before an error cannot leak into the next lock.
  fsm_chk_endly u_endly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .flush (err_ev),
    .en_d2 (en_d2)
  );

  // An enable two clocks ago must show up as an advance; no enable means hold.
  assign en_ok = en_d2 ? !is_hold : is_hold;
`else
  assign en_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      rnd_cnt    <= '0;
      err_info   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      locked     <= (state_d == TRACK);
      err_pulse  <= err_ev;
      err_sticky <= err_sticky_d;
      err_cnt    <= err_cnt_d;
      rnd_cnt    <= rnd_cnt_d;
      err_info   <= err_info_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    err_ev  = 1'b0;
    wrap_ev = 1'b0;

    is_hold = (code == prev_q);
    is_wrap = (32'(prev_q) == LAST_U) && (code == IDLE_C);
    base_ok = next_ok(32'(prev_q), 32'(code), LAST_U);
    legal   = base_ok && en_ok;

    case (state_q)
      SYNC: begin
        if (code == IDLE_C) begin
          state_d = TRACK;
          prev_d  = '0;
        end
      end
      TRACK: begin
        if (legal) begin
          prev_d  = code;
          wrap_ev = is_wrap;
        end else begin
          err_ev  = 1'b1;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // clr is applied first and the current cycle's event on top of it, so a
  // coincident error or wrap is never lost to the clear.
  always_comb begin
    err_base    = clr ? '0 : err_cnt;
    rnd_base    = clr ? '0 : rnd_cnt;
    info_base   = clr ? '0 : err_info;
    sticky_base = clr ? 1'b0 : err_sticky;

    err_cnt_d = err_base;
    if (err_ev && (err_base != '1)) begin
      err_cnt_d = err_base + ERR_W'(1);
    end

    rnd_cnt_d = wrap_ev ? rnd_base + RND_W'(1) : rnd_base;

    err_sticky_d = sticky_base | err_ev;

    err_info_d = info_base;
    if (err_ev && !sticky_base) begin
      err_info_d = {prev_q, code};
    end
  end

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Self-checking bench for fsm_seq_checker: directed scenarios with literal
// expectations plus a randomized run driven by a live stepper with occasional
// corruption, all compared every cycle against a behavioural model.
// Build with CHK_EN_CORR_EN defined to exercise the enable-correlation checks.
module tb_fsm_seq_checker;

  localparam int LAST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [3:0] code = 4'd0;

  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [3:0] err_cnt;
  logic [7:0] rnd_cnt;
  logic [7:0] err_info;

  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  // behavioural model state
  int mTrack, mPrev, mRnd, mErr, mSticky, mInfo, mPulse;
  int enQ[$];

  // live stepper used as a stimulus source
  int stpState, stpOut;

  always #5 clk = ~clk;

  fsm_seq_checker #(
    .CODE_W    (4),
    .LAST_CODE (LAST),
    .RND_W     (8),
    .ERR_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CHK_EN_CORR_EN
    .en         (en),
`endif
    .code       (code),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .rnd_cnt    (rnd_cnt),
    .err_info   (err_info)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int c, input bit cl, input bit e);
    code = 4'(c);
    clr  = cl;
    en   = e;
    @(negedge clk);
  endtask

  task automatic modelReset();
    mTrack = 0; mPrev = 0; mRnd = 0; mErr = 0; mSticky = 0; mInfo = 0; mPulse = 0;
    enQ = '{0, 0};
  endtask

  task automatic modelStep(input int c, input bit cl, input bit e);
    int  enOld;
    bit  hold, adv, ok, bad, wrapped;
    bad = 0;
    wrapped = 0;
    enOld = enQ.pop_front();
    enQ.push_back(int'(e));
    mPulse = 0;
    if (mTrack != 0) begin
      hold = (c == mPrev);
      adv  = (c <= LAST) && (c == (mPrev + 1) % (LAST + 1));
      ok   = hold || adv;
`ifdef CHK_EN_CORR_EN
      ok = ok && ((enOld != 0) ? adv : hold);
`endif
      if (ok) begin
        wrapped = adv && (c == 0);
        mPrev = c;
      end else begin
        bad = 1;
        mTrack = 0;
      end
    end else if (c == 0) begin
      mTrack = 1;
      mPrev = 0;
    end
    if (cl) begin
      mRnd = 0; mErr = 0; mSticky = 0; mInfo = 0;
    end
    if (wrapped) mRnd = (mRnd + 1) % 256;
    if (bad) begin
      mPulse = 1;
      if (mErr < 15) mErr++;
      if (mSticky == 0) mInfo = mPrev * 16 + c;
      mSticky = 1;
      enQ = '{0, 0};
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep(int'(code), clr, en);
    end
  end

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        stpState <= 0;
        stpOut   <= 0;
      end else begin
        stpOut <= stpState;
        if (en) stpState <= (stpState == LAST) ? 0 : stpState + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmpEn && rst_n) begin
        checkOutput("cmp_locked", locked, mTrack);
        checkOutput("cmp_err_pulse", err_pulse, mPulse);
        checkOutput("cmp_err_sticky", err_sticky, mSticky);
        checkOutput("cmp_err_cnt", err_cnt, mErr);
        checkOutput("cmp_rnd_cnt", rnd_cnt, mRnd);
        checkOutput("cmp_err_info", err_info, mInfo);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seqA[] = '{0, 1, 1, 2, 0, 1, 2, 0};
    int pat[]  = '{1, 0, 1, 1, 0};
    int held, c;
    bit cl, e;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_err_pulse", err_pulse, 0);
    checkOutput("reset_err_sticky", err_sticky, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);
    checkOutput("reset_rnd_cnt", rnd_cnt, 0);
    checkOutput("reset_err_info", err_info, 0);
    rst_n = 1'b1;
    cmpEn = 1'b1;

`ifndef CHK_EN_CORR_EN
    // clean rounds
    applyStimulus(0, 0, 0);
    checkOutput("A_lock_first", locked, 1);
    foreach (seqA[i]) applyStimulus(seqA[i], 0, 0);
    checkOutput("A_rnd_cnt", rnd_cnt, 2);
    checkOutput("A_err_cnt", err_cnt, 0);
    checkOutput("A_err_sticky", err_sticky, 0);

    // illegal 1 -> 0, then re-lock
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("B_err_pulse", err_pulse, 1);
    checkOutput("B_err_cnt", err_cnt, 1);
    checkOutput("B_err_info", err_info, 'h10);
    checkOutput("B_unlocked", locked, 0);
    applyStimulus(0, 0, 0);
    checkOutput("B_relock", locked, 1);
    checkOutput("B_pulse_once", err_pulse, 0);

    // out-of-range code, first capture kept
    applyStimulus(0, 1, 0);
    checkOutput("C_clr_err_cnt", err_cnt, 0);
    checkOutput("C_clr_sticky", err_sticky, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(5, 0, 0);
    checkOutput("C_err_info", err_info, 'h25);
    checkOutput("C_err_cnt", err_cnt, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("C_err_cnt2", err_cnt, 2);
    checkOutput("C_err_info_kept", err_info, 'h25);

    // saturation, then clr coincident with an error
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0);
      applyStimulus(3, 0, 0);
    end
    checkOutput("D_err_sat", err_cnt, 15);
    applyStimulus(0, 0, 0);
    applyStimulus(3, 1, 0);
    checkOutput("D_clr_err_cnt", err_cnt, 1);
    checkOutput("D_clr_sticky", err_sticky, 1);
    checkOutput("D_clr_info", err_info, 'h03);
    checkOutput("D_clr_pulse", err_pulse, 1);

    // 256 rounds wrap the round counter
    applyStimulus(0, 1, 0);
    for (int r = 0; r < 256; r++) begin
      applyStimulus(1, 0, 0);
      applyStimulus(2, 0, 0);
      applyStimulus(0, 0, 0);
      if (r == 254) checkOutput("E_rnd_255", rnd_cnt, 255);
    end
    checkOutput("E_rnd_wrap", rnd_cnt, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("E_clr_wrap", rnd_cnt, 1);

    // reset mid-round
    applyStimulus(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("E_rst_locked", locked, 0);
    checkOutput("E_rst_rnd", rnd_cnt, 0);
    checkOutput("E_rst_sticky", err_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 0, 0);
    checkOutput("E_no_lock_on_2", locked, 0);
    applyStimulus(2, 0, 0);
    checkOutput("E_still_unlocked", locked, 0);
    applyStimulus(0, 0, 0);
    checkOutput("E_lock_on_0", locked, 1);
`else
    // live stepper with a repeating enable pattern
    for (int i = 0; i < 30; i++) applyStimulus(stpOut, 0, pat[i % 5]);
    checkOutput("F_no_err_cnt", err_cnt, 0);
    checkOutput("F_no_sticky", err_sticky, 0);
    checkOutput("F_locked", locked, 1);

    // hold forced while the delayed enable demands an advance
    applyStimulus(stpOut, 0, 1);
    applyStimulus(stpOut, 0, 0);
    held = int'(code);
    applyStimulus(held, 0, 0);
    checkOutput("F_force_pulse", err_pulse, 1);
    checkOutput("F_force_err_cnt", err_cnt, 1);
    checkOutput("F_force_unlocked", locked, 0);
`endif

    // randomized run from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      e  = ($urandom_range(0, 1) == 1);
      cl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 6) c = int'($urandom_range(0, 7));
      else c = stpOut;
      applyStimulus(c, cl, e);
    end

    cmpEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_seq_checker.md
Name: fsm_seq_checker

Overview:
Receive-side monitor for the 4-bit state-code stream produced by the three-state stepper (codes IDLE=0, S1=1, S2=2, cycling on enable).
- Samples the code every clock.
- Locks onto the sequence and checks every transition for legality.
- Counts completed rounds (S2->IDLE wraps) and illegal transitions.
- Captures the first offending transition pair.
- Sits beside the stepper on the same clock; used in-system and as a bench scoreboard.

Parameters:
CODE_W, 4, width of observed state code
LAST_CODE, 2, highest legal code; legal set is 0..LAST_CODE
RND_W, 8, width of round counter (wraps modulo 2^RND_W)
ERR_W, 4, width of error counter (saturates at all-ones)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
code  input  CODE_W  observed state code, sampled every rising edge
clr  input  1  synchronous clear of counters, sticky flag and capture
locked  output  1  1 while tracking a legal sequence
err_pulse  output  1  one-cycle pulse per illegal transition
err_sticky  output  1  set on any error, cleared only by clr or reset
err_cnt  output  ERR_W  saturating count of errors
rnd_cnt  output  RND_W  count of completed LAST_CODE->0 wraps
err_info  output  2*CODE_W  {prev_code, bad_code} of first error since clear

Behaviour:
- Reset (rst_n=0, async): state=SYNC, prev=0. All outputs 0.
- All outputs are registered. Effects of a code sampled at edge k are visible after edge k.
- SYNC:
  - locked=0; no checking; out-of-range codes ignored.
  - Code==0 sampled -> TRACK, prev=0, locked=1 after the same edge.
- TRACK, legal transitions (prev -> code):
  - hold: code==prev
  - step: code==prev+1 with prev<LAST_CODE
  - wrap: prev==LAST_CODE and code==0; rnd_cnt+1, wraps to 0 after all-ones
- TRACK, anything else is illegal (includes code>LAST_CODE):
  - err_pulse=1 for exactly one cycle
  - err_cnt+1, saturating
  - err_sticky=1
  - err_info loaded only if err_sticky was 0
  - state->SYNC, locked=0 after the same edge
- Legal samples in TRACK update prev=code.
- Illegal code 0 in TRACK: still an error. Re-lock needs a fresh code==0 sample in SYNC, so it takes effect one cycle later at the earliest.
- clr (synchronous):
  - zeroes err_cnt, rnd_cnt, err_sticky, err_info.
  - Does not change state, prev or locked.
- clr coincident with an error: clear first, then apply the error. Result err_cnt=1, err_sticky=1, err_info=new pair, err_pulse=1.
- clr coincident with a wrap: rnd_cnt=1.
- Reset mid-operation forces SYNC immediately. A partial round is not counted.

Optional Feature:
CHK_EN_CORR_EN
- Defined:
  - Adds input port en (1 bit).
  - Two-stage en delay (en_d1, en_d2) models the stepper's state-register and output-register latency. Both stages reset to 0 and are cleared on entry to SYNC.
  - In TRACK: en_d2=1 requires step or wrap; en_d2=0 requires hold.
  - A mismatch is an illegal transition with identical handling to the base checks.
- Undefined:
  - No en port, no delay line.
  - Hold and advance are both always legal.

Decomposition:
- Package fsm_chk_pkg:
  - checker state enum {SYNC, TRACK}
  - code constants CODE_IDLE=0, CODE_S1=1, CODE_S2=2
  - default LAST_CODE
  - legality function next_ok(prev, code, last)
- Sub-module fsm_chk_endly: the 2-stage en delay with sync flush. Instantiated only under CHK_EN_CORR_EN.
- Top holds the tracker FSM and the counters.

Test Plan:
- Reset then code=0,0,1,1,2,0,1,2,0 -> locked=1 from the first sample, rnd_cnt=2, err_cnt=0, err_sticky=0.
- Locked at prev=1, code=0 -> err_pulse one cycle, err_cnt=1, err_info=0x10, locked=0; then code=0 -> locked=1.
- code=5 while locked at prev=2 -> error, err_info=0x25; a second error 1->0 after re-lock keeps err_info=0x25, err_cnt=2.
- 20 consecutive illegal transitions (re-lock each time) -> err_cnt saturates at 15; clr coincident with a 21st error -> err_cnt=1, err_sticky=1.
- 256 full rounds -> rnd_cnt wraps to 0; assert rst_n low mid-round, release, code=2 -> locked stays 0 until code=0.
- With CHK_EN_CORR_EN, live stepper driven by en pattern 1,0,1,1,0 -> no errors. Force code hold while en_d2=1 -> err_pulse, err_cnt=1.
